// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported word memory between instruction fetch and the data port.
// Grants one requester per transaction, sequences a fixed-latency access and flags stalls.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   output logic              if_stall,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_done,
   output logic              mem_stall,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   localparam int unsigned CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
   localparam int unsigned STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t            state, state_nxt;
   logic              owner_mem, owner_mem_nxt;
   logic              we_q, we_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [DATA_W-1:0] wdata_q, wdata_nxt;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_nxt;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [STV_W-1:0]  starve, starve_nxt;
   logic              grant_mem;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         owner_mem   <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         cnt         <= '0;
         starve      <= '0;
      end else begin
         state       <= state_nxt;
         owner_mem   <= owner_mem_nxt;
         we_q        <= we_nxt;
         addr_q      <= addr_nxt;
         wdata_q     <= wdata_nxt;
         if_rdata_q  <= if_rdata_nxt;
         mem_rdata_q <= mem_rdata_nxt;
         cnt         <= cnt_nxt;
         starve      <= starve_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      owner_mem_nxt = owner_mem;
      we_nxt        = we_q;
      addr_nxt      = addr_q;
      wdata_nxt     = wdata_q;
      if_rdata_nxt  = if_rdata_q;
      mem_rdata_nxt = mem_rdata_q;
      cnt_nxt       = cnt;
      starve_nxt    = starve;
      grant_mem     = 1'b0;

      case (state)
         IDLE: begin
            if (mem_req || if_req) begin
               // IF is forced only once it has watched STARVE_MAX data grants go by
               grant_mem     = mem_req && !(if_req && (starve == STV_W'(STARVE_MAX)));
               owner_mem_nxt = grant_mem;
               cnt_nxt       = CNT_W'(MEM_LAT);
               state_nxt     = ACCESS;
               if (grant_mem) begin
                  addr_nxt  = mem_addr;
                  we_nxt    = mem_we;
                  wdata_nxt = mem_wdata;
                  if (!if_req)
                     starve_nxt = '0;
                  else if (starve != STV_W'(STARVE_MAX))
                     starve_nxt = starve + STV_W'(1);
               end else begin
                  addr_nxt   = if_addr;
                  we_nxt     = 1'b0;
                  starve_nxt = '0;
               end
            end
         end
         ACCESS: begin
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state_nxt = DONE;
               if (!we_q) begin
                  if (owner_mem)
                     mem_rdata_nxt = ram_rdata;
                  else
                     if_rdata_nxt = ram_rdata;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Strobes decode from the async-reset state so they drop as soon as rst asserts
   assign ram_en    = (state == ACCESS) && (cnt == CNT_W'(MEM_LAT));
   assign ram_we    = ram_en && we_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign busy      = (state != IDLE);

   assign if_done   = (state == DONE) && !owner_mem;
   assign mem_done  = (state == DONE) && owner_mem;
   assign if_rdata  = if_rdata_q;
   assign mem_rdata = mem_rdata_q;
   assign if_stall  = if_req && !if_done;
   assign mem_stall = mem_req && !mem_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions plus
// hand sequences for reset abort, simultaneous requests and starvation.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done, if_stall;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_done, mem_stall;
   logic        ram_en, ram_we;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] mem_model [0:255];
   logic        model_init = 1'b0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .MEM_LAT   (2),
      .STARVE_MAX(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_done  (if_done),
      .if_stall (if_stall),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_done (mem_done),
      .mem_stall(mem_stall),
      .ram_en   (ram_en),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata),
      .busy     (busy)
   );

   // memory model: location 5 preloaded with 0xA5, stores land on the ram_en edge
   always @(posedge clk) begin
      if (!model_init) begin
         for (int i = 0; i < 256; i++) mem_model[i] <= 32'h0;
         mem_model[5] <= 32'hA5;
         model_init   <= 1'b1;
      end else if (ram_en && ram_we) begin
         mem_model[ram_addr[7:0]] <= ram_wdata;
      end
   end
   assign ram_rdata = mem_model[ram_addr[7:0]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         chk("ram_we_without_en", {31'b0, ram_we & ~ram_en}, 32'h0);
         chk("ram_en_while_idle", {31'b0, ram_en & ~busy}, 32'h0);
      end
   end

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        mem_req;
      logic        mem_we;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic        exp_mem_owner;
      logic [31:0] exp_addr;
      logic        exp_we;
      logic [31:0] exp_if_rdata;
      logic [31:0] exp_mem_rdata;
   } vec_t;

   vec_t vecs [7];

   int grants;
   int first_if;

   initial begin
      vecs[0] = '{1'b1, 32'd5, 1'b0, 1'b0, 32'd0, 32'h0,        1'b0, 32'd5, 1'b0, 32'hA5,       32'h0};
      vecs[1] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd9, 32'h1234,     1'b1, 32'd9, 1'b1, 32'hA5,       32'h0};
      vecs[2] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd9, 32'h0,        1'b1, 32'd9, 1'b0, 32'hA5,       32'h1234};
      vecs[3] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd3, 32'hDEADBEEF, 1'b1, 32'd3, 1'b1, 32'hA5,       32'h1234};
      vecs[4] = '{1'b1, 32'd3, 1'b0, 1'b0, 32'd0, 32'h0,        1'b0, 32'd3, 1'b0, 32'hDEADBEEF, 32'h1234};
      vecs[5] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd5, 32'h0,        1'b1, 32'd5, 1'b0, 32'hDEADBEEF, 32'hA5};
      vecs[6] = '{1'b1, 32'd9, 1'b0, 1'b0, 32'd0, 32'h0,        1'b0, 32'd9, 1'b0, 32'h1234,     32'hA5};

      rst = 1'b0;
      if_req = 1'b0; if_addr = '0;
      mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
      #12;
      chk("reset_busy",      {31'b0, busy},     32'h0);
      chk("reset_ram_en",    {31'b0, ram_en},   32'h0);
      chk("reset_if_done",   {31'b0, if_done},  32'h0);
      chk("reset_mem_done",  {31'b0, mem_done}, 32'h0);
      chk("reset_if_rdata",  if_rdata,          32'h0);
      chk("reset_mem_rdata", mem_rdata,         32'h0);
      chk("reset_ram_addr",  ram_addr,          32'h0);
      rst = 1'b1;
      tick;

      // single transactions; addresses scrambled mid-access to prove the latched copy is used
      for (int v = 0; v < 7; v++) begin
         if_req = vecs[v].if_req;   if_addr = vecs[v].if_addr;
         mem_req = vecs[v].mem_req; mem_we = vecs[v].mem_we;
         mem_addr = vecs[v].mem_addr; mem_wdata = vecs[v].mem_wdata;
         tick;
         chk("vec_ram_en",   {31'b0, ram_en}, 32'h1);
         chk("vec_ram_addr", ram_addr,        vecs[v].exp_addr);
         chk("vec_ram_we",   {31'b0, ram_we}, {31'b0, vecs[v].exp_we});
         chk("vec_busy",     {31'b0, busy},   32'h1);
         chk("vec_stall",    {31'b0, (vecs[v].exp_mem_owner ? mem_stall : if_stall)}, 32'h1);
         if_addr = 32'hFF; mem_addr = 32'hFF; mem_wdata = 32'hFFFF;
         tick;
         chk("vec_ram_en_once", {31'b0, ram_en}, 32'h0);
         chk("vec_addr_held",   ram_addr,        vecs[v].exp_addr);
         tick;
         chk("vec_if_done",   {31'b0, if_done},  {31'b0, ~vecs[v].exp_mem_owner});
         chk("vec_mem_done",  {31'b0, mem_done}, {31'b0, vecs[v].exp_mem_owner});
         chk("vec_if_rdata",  if_rdata,          vecs[v].exp_if_rdata);
         chk("vec_mem_rdata", mem_rdata,         vecs[v].exp_mem_rdata);
         chk("vec_stall_done", {31'b0, if_stall | mem_stall}, 32'h0);
         if_req = 1'b0; mem_req = 1'b0;
         tick;
         chk("vec_idle_busy", {31'b0, busy},               32'h0);
         chk("vec_done_pulse", {31'b0, if_done | mem_done}, 32'h0);
      end

      // simultaneous requests: MEM load of 5 first, then IF fetch of 3
      if_req = 1'b1; if_addr = 32'd3;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'd5;
      tick;
      chk("sim_first_addr", ram_addr,          32'd5);
      chk("sim_if_stall1",  {31'b0, if_stall}, 32'h1);
      tick;
      tick;
      chk("sim_mem_done",   {31'b0, mem_done}, 32'h1);
      chk("sim_if_not_done", {31'b0, if_done}, 32'h0);
      chk("sim_mem_stall",  {31'b0, mem_stall}, 32'h0);
      chk("sim_if_stall2",  {31'b0, if_stall}, 32'h1);
      chk("sim_mem_rdata",  mem_rdata,         32'hA5);
      mem_req = 1'b0;
      tick;
      chk("sim_if_stall3",  {31'b0, if_stall}, 32'h1);
      tick;
      chk("sim_second_en",  {31'b0, ram_en},   32'h1);
      chk("sim_second_addr", ram_addr,         32'd3);
      tick;
      tick;
      chk("sim_if_done",    {31'b0, if_done},  32'h1);
      chk("sim_if_stall4",  {31'b0, if_stall}, 32'h0);
      chk("sim_if_rdata",   if_rdata,          32'hDEADBEEF);
      if_req = 1'b0;
      tick;

      // starvation: MEM load of 9 held continuously, IF fetch of 5 pending
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'd9;
      if_req = 1'b1; if_addr = 32'd5;
      grants = 0; first_if = 0;
      for (int c = 0; c < 80 && first_if == 0; c++) begin
         tick;
         if (ram_en) begin
            grants++;
            if (ram_addr == 32'd5) first_if = grants;
         end
      end
      chk("starve_if_grant_no", first_if, 32'd5);
      tick;
      tick;
      chk("starve_if_done", {31'b0, if_done}, 32'h1);
      chk("starve_if_rdata", if_rdata,        32'hA5);
      if_req = 1'b0; mem_req = 1'b0;
      tick;

      // reset mid-access: fetch of 5 aborted in its ram_en cycle
      if_req = 1'b1; if_addr = 32'd5;
      tick;
      chk("rst_pre_ram_en", {31'b0, ram_en}, 32'h1);
      #2 rst = 1'b0;
      #1;
      chk("rst_ram_en",    {31'b0, ram_en},  32'h0);
      chk("rst_busy",      {31'b0, busy},    32'h0);
      chk("rst_if_done",   {31'b0, if_done}, 32'h0);
      chk("rst_if_rdata",  if_rdata,         32'h0);
      chk("rst_mem_rdata", mem_rdata,        32'h0);
      if_req = 1'b0;
      #1 rst = 1'b1;
      tick;
      chk("rst_after_busy",   {31'b0, busy},    32'h0);
      chk("rst_after_ram_en", {31'b0, ram_en},  32'h0);
      chk("rst_after_done",   {31'b0, if_done}, 32'h0);
      tick;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
